// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA pixel timing, clamped address publish and one-pixel colour/sync pipeline
// Optional 8-bar test pattern is compiled in with VGA_TEST_PATTERN_EN (adds TEST_MODE input).
module vga_timing_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] COLOUR_IN,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       TEST_MODE,
`endif
  output logic [7:0] COLOUR_OUT,
  output logic       HS,
  output logic       VS,
  output logic [9:0] ADDRH,
  output logic [8:0] ADDRV,
  output logic       REFRESH
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0]       V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0]       H_VIS_C    = 10'(H_VIS);
  localparam logic [9:0]       V_VIS_C    = 10'(V_VIS);
  localparam logic [9:0]       H_ADDR_MAX = 10'(H_VIS - 1);
  localparam logic [8:0]       V_ADDR_MAX = 9'(V_VIS - 1);
  localparam logic [9:0]       HS_START   = 10'(H_VIS + H_FP);
  localparam logic [9:0]       HS_END     = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]       VS_START   = 10'(V_VIS + V_FP);
  localparam logic [9:0]       VS_END     = 10'(V_VIS + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_hcnt;
  logic [9:0]       r_vcnt;
  logic [9:0]       r_addrh;
  logic [8:0]       r_addrv;
  logic [7:0]       r_colour;
  logic             r_hs;
  logic             r_vs;
  logic             r_refresh;

  logic             w_tick;
  logic             w_hwrap;
  logic [9:0]       w_hnext;
  logic [9:0]       w_vnext;
  logic [9:0]       w_addrh;
  logic [8:0]       w_addrv;
  logic             w_vis;
  logic             w_hs_active;
  logic             w_vs_active;
  logic [7:0]       w_colour;

  assign w_tick  = (r_div == DIV_LAST);
  assign w_hwrap = (r_hcnt == H_LAST);
  assign w_hnext = w_hwrap ? 10'd0 : r_hcnt + 10'd1;

  always_comb begin
    w_vnext = r_vcnt;
    if (w_hwrap) begin
      w_vnext = (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
    end
  end

  // Clamp so the upstream stage only ever sees in-range coordinates.
  assign w_addrh = (w_hnext < H_VIS_C) ? w_hnext : H_ADDR_MAX;
  assign w_addrv = (w_vnext < V_VIS_C) ? w_vnext[8:0] : V_ADDR_MAX;

  // r_hcnt/r_vcnt still hold the coordinate published on the previous tick.
  assign w_vis       = (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
  assign w_hs_active = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
  assign w_vs_active = (r_vcnt >= VS_START) && (r_vcnt < VS_END);

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] w_bar_idx;
  logic [2:0] w_bar;

  assign w_bar_idx = r_hcnt / 10'd80;
  assign w_bar     = (w_bar_idx > 10'd7) ? 3'd7 : w_bar_idx[2:0];

  always_comb begin
    w_colour = 8'h00;
    if (w_vis) begin
      if (TEST_MODE) begin
        w_colour = {{3{w_bar[2]}}, {3{w_bar[1]}}, {2{w_bar[0]}}};
      end else begin
        w_colour = COLOUR_IN;
      end
    end
  end
`else
  always_comb begin
    w_colour = 8'h00;
    if (w_vis) begin
      w_colour = COLOUR_IN;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_div     <= '0;
      r_hcnt    <= 10'd0;
      r_vcnt    <= 10'd0;
      r_addrh   <= 10'd0;
      r_addrv   <= 9'd0;
      r_colour  <= 8'h00;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_refresh <= 1'b0;
    end else begin
      r_refresh <= 1'b0;
      r_div     <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_hcnt    <= w_hnext;
        r_vcnt    <= w_vnext;
        r_addrh   <= w_addrh;
        r_addrv   <= w_addrv;
        r_colour  <= w_colour;
        r_hs      <= ~w_hs_active;
        r_vs      <= ~w_vs_active;
        r_refresh <= (w_hnext == 10'd0) && (w_vnext == V_VIS_C);
      end
    end
  end

  assign COLOUR_OUT = r_colour;
  assign HS         = r_hs;
  assign VS         = r_vs;
  assign ADDRH      = r_addrh;
  assign ADDRV      = r_addrv;
  assign REFRESH    = r_refresh;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen with default line timing and a shortened frame
module tb_vga_timing_gen;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] COLOUR_IN = 8'h00;
  logic [7:0] COLOUR_OUT;
  logic       HS;
  logic       VS;
  logic [9:0] ADDRH;
  logic [8:0] ADDRV;
  logic       REFRESH;
`ifdef VGA_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  always #5 CLK = ~CLK;

  // Line timing at defaults; frame shortened to 4 visible + 1 FP + 2 sync + 1 BP lines.
  vga_timing_gen #(
    .CLK_DIV(2), .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .COLOUR_IN(COLOUR_IN),
`ifdef VGA_TEST_PATTERN_EN
    .TEST_MODE(test_mode),
`endif
    .COLOUR_OUT(COLOUR_OUT),
    .HS(HS),
    .VS(VS),
    .ADDRH(ADDRH),
    .ADDRV(ADDRV),
    .REFRESH(REFRESH)
  );

  // Upstream stage: registers colour one CLK after the address.
  always @(posedge CLK) COLOUR_IN <= ADDRH[7:0];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int rel = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  bit   mon_en = 1'b0;
  logic p_hs = 1'b1;
  logic p_vs = 1'b1;
  int   hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], rf_at[$];
  int   nz_vblank = 0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (p_hs && !HS) hs_fall.push_back(cyc);
      if (!p_hs && HS) hs_rise.push_back(cyc);
      if (p_vs && !VS) vs_fall.push_back(cyc);
      if (!p_vs && VS) vs_rise.push_back(cyc);
      if (REFRESH) rf_at.push_back(cyc);
      if (!VS && COLOUR_OUT != 8'h00) nz_vblank++;
      p_hs = HS;
      p_vs = VS;
    end
  end

  task automatic goto_tick(input int k);
    while (cyc < rel + 2 * k) @(negedge CLK);
  endtask

  task automatic release_reset();
    RESET = 1'b0;
    rel = cyc;
    hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete(); rf_at.delete();
    nz_vblank = 0;
    mon_en = 1'b1;
  endtask

  task automatic check_frames();
    chk("hs_fall_count", 32'(hs_fall.size() >= 2), 1);
    chk("hs_rise_count", 32'(hs_rise.size() >= 1), 1);
    chk("vs_fall_count", 32'(vs_fall.size() >= 2), 1);
    chk("vs_rise_count", 32'(vs_rise.size() >= 1), 1);
    chk("refresh_count", 32'(rf_at.size()), 2);
    if (hs_fall.size() >= 2 && hs_rise.size() >= 1) begin
      chk("hs_first_fall", 32'(hs_fall[0] - rel), 1314);
      chk("hs_period", 32'(hs_fall[1] - hs_fall[0]), 1600);
      chk("hs_low_width", 32'(hs_rise[0] - hs_fall[0]), 192);
    end
    if (vs_fall.size() >= 2 && vs_rise.size() >= 1) begin
      chk("vs_first_fall", 32'(vs_fall[0] - rel), 8002);
      chk("vs_period", 32'(vs_fall[1] - vs_fall[0]), 12800);
      chk("vs_low_width", 32'(vs_rise[0] - vs_fall[0]), 3200);
    end
    if (rf_at.size() == 2) begin
      chk("refresh_first", 32'(rf_at[0] - rel), 6400);
      chk("refresh_period", 32'(rf_at[1] - rf_at[0]), 12800);
    end
    chk("vblank_colour_nonzero", 32'(nz_vblank), 0);
  endtask

  int ph;
  int hc;

  initial begin
    RESET = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    chk("rst_colour", 32'(COLOUR_OUT), 0);
    chk("rst_hs", 32'(HS), 1);
    chk("rst_vs", 32'(VS), 1);
    chk("rst_addrh", 32'(ADDRH), 0);
    chk("rst_addrv", 32'(ADDRV), 0);
    chk("rst_refresh", 32'(REFRESH), 0);

    release_reset();
    @(negedge CLK);
    chk("addrh_after_1clk", 32'(ADDRH), 0);
    @(negedge CLK);
    chk("addrh_after_2clk", 32'(ADDRH), 1);

    for (int k = 1; k <= 801; k++) begin
      goto_tick(k);
      hc = k % 800;
      ph = (k - 1) % 800;
      chk("line0_addrh", 32'(ADDRH), (hc < 640) ? hc : 639);
      chk("line0_addrv", 32'(ADDRV), (k >= 800) ? 1 : 0);
      chk("line0_colour", 32'(COLOUR_OUT), (ph < 640) ? (ph % 256) : 0);
      chk("line0_hs", 32'(HS), (ph >= 656 && ph < 752) ? 0 : 1);
    end

    goto_tick(4000);
    chk("vs_before_sync", 32'(VS), 1);
    chk("addrv_clamp", 32'(ADDRV), 3);
    goto_tick(4001);
    chk("vs_sync_start", 32'(VS), 0);
    goto_tick(6400);
    chk("wrap_addrh", 32'(ADDRH), 0);
    chk("wrap_addrv", 32'(ADDRV), 0);
    chk("wrap_no_refresh", 32'(REFRESH), 0);
    goto_tick(9600);
    chk("refresh_high", 32'(REFRESH), 1);
    chk("refresh_addrv", 32'(ADDRV), 3);
    @(negedge CLK);
    chk("refresh_one_clk", 32'(REFRESH), 0);
    goto_tick(10500);
    check_frames();

    goto_tick(15100);
    chk("mid_hs_low", 32'(HS), 0);
    chk("mid_addrh", 32'(ADDRH), 639);
    chk("mid_addrv", 32'(ADDRV), 2);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_hs", 32'(HS), 1);
    chk("mid_rst_vs", 32'(VS), 1);
    chk("mid_rst_addrh", 32'(ADDRH), 0);
    chk("mid_rst_addrv", 32'(ADDRV), 0);
    chk("mid_rst_colour", 32'(COLOUR_OUT), 0);
    repeat (3) @(negedge CLK);
    release_reset();
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_rel_addrh", 32'(ADDRH), 1);
    goto_tick(10500);
    check_frames();

`ifdef VGA_TEST_PATTERN_EN
    test_mode = 1'b1;
    for (int k = 12801; k <= 13442; k++) begin
      goto_tick(k);
      ph = k - 12801;
      chk("bar_colour", 32'(COLOUR_OUT),
          (ph < 640) ? ({{3{(ph / 80) >= 4}}, {3{((ph / 80) % 4) >= 2}}, {2{((ph / 80) % 2) == 1}}}) : 0);
    end
    test_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
